// File: rtl/mul_lane_scheduler.sv
// Round-robin multi-lane multiplier: arbitrates NREQ requesters into an elastic Wallace-tree pipeline.
// Define MUL_SCHED_TREE_REG_EN to add the registered tree stage S2 (latency 3 instead of 2).

module wallace_tree_multiplier #(
  parameter int BITS  = 24,
  parameter int WIDTH = 2*BITS
) (
  input  logic [BITS*WIDTH-1:0] pp_i,
  output logic [WIDTH-1:0]      sum_o,
  output logic [WIDTH-1:0]      carry_o
);

  logic [WIDTH-1:0] rows [BITS];
  logic [WIDTH-1:0] nxt  [BITS];
  int               n_rows;
  int               n_next;

  // Each level folds every full group of three rows into a sum/carry pair with 3:2 counters;
  // leftover rows pass through untouched until only two rows remain.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every variable a default first,
    // so no latch is inferred; clocked blocks use '<=' only.
    for (int j = 0; j < BITS; j++) begin
      rows[j] = pp_i[j*WIDTH +: WIDTH];
      nxt[j]  = '0;
    end
    n_rows = BITS;
    n_next = 0;
    for (int lvl = 0; lvl < BITS; lvl++) begin
      if (n_rows > 2) begin
        for (int k = 0; k < BITS; k++) nxt[k] = '0;
        n_next = 0;
        for (int g = 0; g < BITS/3; g++) begin
          if (3*g + 2 < n_rows) begin
            nxt[n_next]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            nxt[n_next+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                             (rows[3*g+1] & rows[3*g+2])) << 1;
            n_next = n_next + 2;
          end
        end
        for (int r = 0; r < BITS; r++) begin
          if (r >= (n_rows/3)*3 && r < n_rows) begin
            nxt[n_next] = rows[r];
            n_next = n_next + 1;
          end
        end
        for (int k = 0; k < BITS; k++) rows[k] = nxt[k];
        n_rows = n_next;
      end
    end
    sum_o   = rows[0];
    carry_o = (n_rows > 1) ? rows[1] : '0;
  end

endmodule

module mul_lane_scheduler #(
  parameter int BITS  = 24,
  parameter int WIDTH = 2*BITS,
  parameter int NREQ  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*BITS-1:0]     req_a_i,
  input  logic [NREQ*BITS-1:0]     req_b_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [$clog2(NREQ)-1:0]  res_id_o,
  output logic [WIDTH-1:0]         res_data_o,
  output logic [1:0]               inflight_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]        rr_q, rr_d;
  logic                  grant_found;
  logic [IDW-1:0]        grant_id;
  logic [NREQ-1:0]       grant_oh;
  int                    arb_idx;
  logic [BITS-1:0]       a_sel, b_sel;
  logic [BITS*WIDTH-1:0] pp_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [IDW-1:0]        s1_id_q;
  logic [BITS*WIDTH-1:0] s1_pp_q;

  logic [WIDTH-1:0]      tree_sum, tree_carry;
  logic                  res_valid_q, res_valid_d;
  logic [IDW-1:0]        res_id_q, res_id_d;
  logic [WIDTH-1:0]      res_data_q, res_data_d;

  logic                  out_can, s1_fwd_can, s1_can, accept, res_load;
  logic                  src_valid;
  logic [IDW-1:0]        src_id;
  logic [WIDTH-1:0]      src_sum, src_carry;

`ifdef MUL_SCHED_TREE_REG_EN
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_can, s2_load;
  logic [IDW-1:0]        s2_id_q;
  logic [WIDTH-1:0]      s2_sum_q, s2_carry_q;
`endif

  // Round-robin pick: first valid lane at or after rr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx = int'(rr_q) + i;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!grant_found && req_valid_i[arb_idx]) begin
        grant_found = 1'b1;
        grant_id    = arb_idx[IDW-1:0];
      end
    end
    grant_oh = grant_found ? (NREQ'(1) << grant_id) : '0;
  end

  always_comb begin
    a_sel = req_a_i[grant_id*BITS +: BITS];
    b_sel = req_b_i[grant_id*BITS +: BITS];
    pp_d  = '0;
    for (int j = 0; j < BITS; j++) begin
      pp_d[j*WIDTH +: WIDTH] = b_sel[j] ? (WIDTH'(a_sel) << j) : '0;
    end
  end

  wallace_tree_multiplier #(
    .BITS  (BITS),
    .WIDTH (WIDTH)
  ) u_tree (
    .pp_i    (s1_pp_q),
    .sum_o   (tree_sum),
    .carry_o (tree_carry)
  );

  // Elastic handshake: a stage may load when it is empty or its content moves on this edge.
  always_comb begin
    out_can = !res_valid_q || res_ready_i;
`ifdef MUL_SCHED_TREE_REG_EN
    s2_can     = !s2_valid_q || out_can;
    s1_fwd_can = s2_can;
    s2_load    = s1_valid_q && s2_can;
    s2_valid_d = s2_load || (s2_valid_q && !out_can);
    src_valid  = s2_valid_q;
    src_id     = s2_id_q;
    src_sum    = s2_sum_q;
    src_carry  = s2_carry_q;
`else
    s1_fwd_can = out_can;
    src_valid  = s1_valid_q;
    src_id     = s1_id_q;
    src_sum    = tree_sum;
    src_carry  = tree_carry;
`endif
    s1_can      = !s1_valid_q || s1_fwd_can;
    accept      = grant_found && s1_can && !rst_i;
    req_ready_o = (rst_i || !s1_can) ? '0 : grant_oh;
    s1_valid_d  = accept || (s1_valid_q && !s1_fwd_can);

    res_load    = src_valid && out_can;
    res_valid_d = res_load || (res_valid_q && !res_ready_i);
    res_id_d    = res_load ? src_id : res_id_q;
    res_data_d  = res_load ? (src_sum + src_carry) : res_data_q;

    rr_d = rr_q;
    if (accept) rr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      s1_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
`ifdef MUL_SCHED_TREE_REG_EN
      s2_valid_q  <= 1'b0;
`endif
    end else begin
      rr_q        <= rr_d;
      s1_valid_q  <= s1_valid_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
`ifdef MUL_SCHED_TREE_REG_EN
      s2_valid_q  <= s2_valid_d;
`endif
    end
  end

  // NOTE: inner-stage payload registers carry no reset; their valid bits gate every use,
  // which keeps the wide partial-product bank free of reset fan-out.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_id_q <= grant_id;
      s1_pp_q <= pp_d;
    end
`ifdef MUL_SCHED_TREE_REG_EN
    if (s2_load) begin
      s2_id_q    <= s1_id_q;
      s2_sum_q   <= tree_sum;
      s2_carry_q <= tree_carry;
    end
`endif
  end

  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_data_o  = res_data_q;
`ifdef MUL_SCHED_TREE_REG_EN
  assign inflight_o  = 2'(s1_valid_q) + 2'(s2_valid_q) + 2'(res_valid_q);
`else
  assign inflight_o  = 2'(s1_valid_q) + 2'(res_valid_q);
`endif

endmodule

// File: tb/tb_mul_lane_scheduler.sv
// Self-checking bench for mul_lane_scheduler: directed corner cases plus randomized traffic
// scored against an in-order queue model of accepted products.

module tb_mul_lane_scheduler;

  localparam int BITS  = 24;
  localparam int WIDTH = 2*BITS;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
`ifdef MUL_SCHED_TREE_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*BITS-1:0] req_a_i, req_b_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [IDW-1:0]       res_id_o;
  logic [WIDTH-1:0]     res_data_o;
  logic [1:0]           inflight_o;

  mul_lane_scheduler #(.BITS(BITS), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_id_o    (res_id_o),
    .res_data_o  (res_data_o),
    .inflight_o  (inflight_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rr_m = 0;
  int          dut_grant = -1;
  int          retired = 0;
  bit          prev_stall = 1'b0;
  logic [IDW-1:0]   prev_id;
  logic [WIDTH-1:0] prev_data;
  logic [63:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge; checks DUT against the model,
  // advances the model across the rising edge, and returns at the next negedge.
  task automatic step();
    int               g;
    int               idx;
    bit               can;
    logic [NREQ-1:0]  exp_rdy;
    logic [BITS-1:0]  a, b;
    exp_t             e;
    #1;
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      idx = (rr_m + i) % NREQ;
      if (g < 0 && req_valid_i[idx]) g = idx;
    end
    can     = !(exp_q.size() == LAT && !res_ready_i);
    exp_rdy = (g >= 0 && can && !rst_i) ? (NREQ'(1) << g) : '0;
    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    dut_grant = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) dut_grant = i;
    if (!rst_i) begin
      check("inflight", 64'(inflight_o), 64'(exp_q.size()));
      if (prev_stall) begin
        check("stall_valid", 64'(res_valid_o), 64'd1);
        check("stall_id",    64'(res_id_o),    64'(prev_id));
        check("stall_data",  64'(res_data_o),  64'(prev_data));
      end
      if (res_valid_o) begin
        if (exp_q.size() == 0) check("spurious_result", 64'(res_valid_o), 64'd0);
        else begin
          check("res_id",   64'(res_id_o),   64'(exp_q[0].id));
          check("res_data", 64'(res_data_o), exp_q[0].data);
        end
      end
    end
    if (rst_i) begin
      exp_q.delete();
      rr_m       = 0;
      prev_stall = 1'b0;
    end else begin
      if (res_valid_o && res_ready_i && exp_q.size() > 0) begin
        last_data = 64'(res_data_o);
        void'(exp_q.pop_front());
        retired++;
      end
      if (exp_rdy != '0) begin
        a      = req_a_i[g*BITS +: BITS];
        b      = req_b_i[g*BITS +: BITS];
        e.id   = g;
        e.data = 64'(a) * 64'(b);
        exp_q.push_back(e);
        rr_m = (g + 1) % NREQ;
      end
      prev_stall = res_valid_o && !res_ready_i;
      prev_id    = res_id_o;
      prev_data  = res_data_o;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    int n = 0;
    req_valid_i = '0;
    res_ready_i = 1'b1;
    while ((exp_q.size() != 0 || res_valid_o) && n < 20) begin
      step();
      n++;
    end
    check("drain_valid",    64'(res_valid_o), 64'd0);
    check("drain_inflight", 64'(inflight_o),  64'd0);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic do_op(input int lane, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int n = 0;
    req_valid_i = '0;
    req_valid_i[lane] = 1'b1;
    req_a_i[lane*BITS +: BITS] = a;
    req_b_i[lane*BITS +: BITS] = b;
    res_ready_i = 1'b1;
    do begin
      step();
      n++;
    end while (dut_grant != lane && n < 10);
    check("op_accepted", 64'(dut_grant), 64'(lane));
    drain();
  endtask

  function automatic logic [BITS-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return BITS'(1);
      2:       return '1;
      3:       return BITS'(1) << (BITS-1);
      default: return BITS'($urandom);
    endcase
  endfunction

  initial begin
    int edges;
    int cyc;
    logic [BITS-1:0] r;
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    res_ready_i = 1'b1;
    @(negedge clk_i);
    step();
    step();
    rst_i = 1'b0;
    check("rst_res_valid", 64'(res_valid_o), 64'd0);
    check("rst_res_id",    64'(res_id_o),    64'd0);
    check("rst_res_data",  64'(res_data_o),  64'd0);
    check("rst_inflight",  64'(inflight_o),  64'd0);

    // Lane 2 alone, all-ones operands: latency and full-width product.
    req_valid_i = 4'b0100;
    req_a_i[2*BITS +: BITS] = 24'hFFFFFF;
    req_b_i[2*BITS +: BITS] = 24'hFFFFFF;
    step();
    req_valid_i = '0;
    edges = 1;
    while (!res_valid_o && edges < 10) begin
      step();
      edges++;
    end
    check("latency",   64'(edges),      64'(LAT));
    check("max_id",    64'(res_id_o),   64'd2);
    check("max_data",  64'(res_data_o), 64'hFFFFFE000001);
    drain();

    // All lanes valid from rr_ptr=0: grants rotate one per cycle.
    do_reset();
    req_valid_i = '1;
    for (int k = 0; k < NREQ; k++) begin
      req_a_i[k*BITS +: BITS] = BITS'($urandom);
      req_b_i[k*BITS +: BITS] = BITS'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_grant", 64'(dut_grant), 64'(i % NREQ));
    end

    // Consumer stalls for 5 cycles with lanes still requesting.
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    check("stall_fill_inflight", 64'(inflight_o),  64'(LAT));
    check("stall_fill_ready",    64'(req_ready_o), 64'd0);
    check("stall_fill_valid",    64'(res_valid_o), 64'd1);
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drain();

    // Reset with the pipeline full: nothing stale may surface afterwards.
    req_valid_i = '1;
    res_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    #1;
    check("midrst_valid",    64'(res_valid_o), 64'd0);
    check("midrst_inflight", 64'(inflight_o),  64'd0);
    req_valid_i = '1;
    res_ready_i = 1'b1;
    step();
    check("midrst_rr_ptr", 64'(dut_grant), 64'd0);
    drain();

    // Operand corners.
    r = BITS'($urandom) | BITS'(1);
    do_op(1, '0, r);
    check("a_zero", last_data, 64'd0);
    do_op(3, r, '0);
    check("b_zero", last_data, 64'd0);
    do_op(0, BITS'(1), 24'h800000);
    check("a1_b800000", last_data, 64'h000000800000);

    // Randomized traffic until 10k products retire.
    retired = 0;
    cyc     = 0;
    while (retired < 10000 && cyc < 40000) begin
      for (int k = 0; k < NREQ; k++) begin
        req_valid_i[k] = ($urandom_range(0, 3) != 0);
        req_a_i[k*BITS +: BITS] = pick_operand();
        req_b_i[k*BITS +: BITS] = pick_operand();
      end
      res_ready_i = ($urandom_range(0, 7) != 0);
      step();
      cyc++;
    end
    drain();
    check("random_retired", 64'(retired >= 10000), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
